// File: rtl/iic_init_pkg.sv
// Shared types for the SCCB init-table sequencer.
package iic_init_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PWR_WAIT,
    FETCH,
    LOAD,
    REQ,
    XFER,
    GAP,
    DELAY,
    NEXT,
    DONE
  } seq_state_t;

  // A table entry with this register field is a delay of 'val' ms, not a write.
  localparam logic [15:0] DELAY_TAG = 16'hFFFF;

  typedef struct packed {
    logic [15:0] rg;
    logic [7:0]  val;
  } tbl_entry_t;

endpackage

// File: rtl/iic_ms_timer.sv
// Millisecond down-counter: load N ms, one-cycle done pulse N*CLK_FRE*1000 cycles later.
// N=0 pulses done on the cycle right after the load.
module iic_ms_timer #(
  parameter int CLK_FRE = 50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_ms,
  output logic       o_done
);

  localparam int CYC_PER_MS = CLK_FRE * 1000;
  localparam int CW         = $clog2(CYC_PER_MS);

  logic [CW-1:0] r_cyc;
  logic [7:0]    r_ms;
  logic          r_run;
  logic          r_done;

  // Cycle counter inside each ms, ms counter above it, done raised on the final wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cyc  <= '0;
      r_ms   <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_cyc  <= CW'(CYC_PER_MS - 1);
        r_ms   <= i_ms;
        r_run  <= (i_ms != 8'd0);
        r_done <= (i_ms == 8'd0);
      end else if (r_run) begin
        if (r_cyc == '0) begin
          r_cyc <= CW'(CYC_PER_MS - 1);
          r_ms  <= r_ms - 8'd1;
          if (r_ms == 8'd1) begin
            r_run  <= 1'b0;
            r_done <= 1'b1;
          end
        end else begin
          r_cyc <= r_cyc - CW'(1);
        end
      end
    end
  end

  assign o_done = r_done;

endmodule

// File: rtl/iic_init_seq.sv
// OV5640 init-table sequencer: walks {reg,val} ROM entries, issues one single-byte
// SCCB write per entry via iic_master, and honours power-up and in-table delays.
module iic_init_seq
  import iic_init_pkg::*;
#(
  parameter int          CLK_FRE      = 50,
  parameter int          PWR_DELAY_MS = 20,
  parameter int          TBL_AW       = 8,
  parameter int          TBL_LEN      = 256,
  parameter logic [7:0]  SLAVE_ADDR   = 8'h78,
  parameter int          GAP_CYC      = 200,
  parameter int          REQ_TIMEOUT  = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic [TBL_AW-1:0] o_tbl_addr,
  input  logic [23:0]       i_tbl_data,
  output logic [7:0]        o_iic_slave_addr,
  output logic              o_iic_send_rw,
  output logic [15:0]       o_iic_reg_addr,
  output logic [7:0]        o_iic_send_data,
  output logic              o_iic_send_en,
  output logic              o_iic_brust_vaild,
  input  logic              i_iic_send_busy,
  output logic              o_init_busy,
  output logic              o_init_done,
  output logic [TBL_AW-1:0] o_entry_idx
);

  // One counter serves both the GAP length and the REQ timeout.
  localparam int CNT_MAX = (GAP_CYC > REQ_TIMEOUT) ? GAP_CYC : REQ_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  seq_state_t        r_state, w_nxt;
  logic              r_busy_m, r_busy_s;
  logic [TBL_AW-1:0] r_idx;
  logic [15:0]       r_reg_addr;
  logic [7:0]        r_send_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_drop;
  logic              w_tmr_load;
  logic [7:0]        w_tmr_ms;
  logic              w_tmr_done;
  logic              w_last;
  logic              w_gap_end;
  logic              w_to_hit;
  tbl_entry_t        w_ent;

  assign w_ent     = i_tbl_data;
  assign w_last    = (r_idx == TBL_AW'(TBL_LEN - 1));
  assign w_gap_end = (r_cnt == CNT_W'(GAP_CYC - 1));
  assign w_to_hit  = (r_state == REQ) && !r_busy_s && !r_drop &&
                     (r_cnt == CNT_W'(REQ_TIMEOUT - 1));

  iic_ms_timer #(.CLK_FRE(CLK_FRE)) u_tmr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_tmr_load),
    .i_ms    (w_tmr_ms),
    .o_done  (w_tmr_done)
  );

  // busy comes from the scl_x2 domain: two-flop synchroniser before any use.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy_m <= 1'b0;
      r_busy_s <= 1'b0;
    end else begin
      r_busy_m <= i_iic_send_busy;
      r_busy_s <= r_busy_m;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nxt;
  end

  // Next state; timer is loaded on the transition into PWR_WAIT/DELAY.
  always_comb begin
    w_nxt      = r_state;
    w_tmr_load = 1'b0;
    w_tmr_ms   = 8'd0;
    case (r_state)
      IDLE: begin
        w_nxt      = PWR_WAIT;
        w_tmr_load = 1'b1;
        w_tmr_ms   = 8'(PWR_DELAY_MS);
      end
      PWR_WAIT: if (w_tmr_done) w_nxt = FETCH;
      FETCH:    w_nxt = LOAD;
      LOAD: begin
        if (w_ent.rg == DELAY_TAG) begin
          w_nxt      = DELAY;
          w_tmr_load = 1'b1;
          w_tmr_ms   = w_ent.val;
        end else begin
          w_nxt = REQ;
        end
      end
      REQ:      if (r_busy_s)   w_nxt = XFER;
      XFER:     if (!r_busy_s)  w_nxt = GAP;
      GAP:      if (w_gap_end)  w_nxt = NEXT;
      DELAY:    if (w_tmr_done) w_nxt = NEXT;
      NEXT:     w_nxt = w_last ? DONE : FETCH;
      DONE: begin
        if (i_start) begin
          w_nxt      = PWR_WAIT;
          w_tmr_load = 1'b1;
          w_tmr_ms   = 8'(PWR_DELAY_MS);
        end
      end
      default:  w_nxt = IDLE;
    endcase
  end

  // Entry index: cleared at every run start, stepped in NEXT, never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                             r_idx <= '0;
    else if (w_tmr_load && w_nxt == PWR_WAIT) r_idx <= '0;
    else if (r_state == NEXT && !w_last)      r_idx <= r_idx + TBL_AW'(1);
  end

  // Write payload held from LOAD until the next write entry's LOAD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reg_addr  <= '0;
      r_send_data <= '0;
    end else if (r_state == LOAD && w_ent.rg != DELAY_TAG) begin
      r_reg_addr  <= w_ent.rg;
      r_send_data <= w_ent.val;
    end
  end

  // GAP / timeout counter; held at 0 during the one-cycle request drop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_to_hit;
      if (r_state != w_nxt || r_drop || w_to_hit) r_cnt <= '0;
      else if (r_state == REQ || r_state == GAP)  r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tbl_addr        = r_idx;
  assign o_entry_idx       = r_idx;
  assign o_iic_slave_addr  = SLAVE_ADDR;
  assign o_iic_send_rw     = 1'b0;
  assign o_iic_brust_vaild = 1'b0;
  assign o_iic_reg_addr    = r_reg_addr;
  assign o_iic_send_data   = r_send_data;
  assign o_iic_send_en     = (r_state == REQ) && !r_drop;
  assign o_init_busy       = (r_state != IDLE) && (r_state != DONE);
  assign o_init_done       = (r_state == DONE);

endmodule

// File: tb/tb_iic_init_seq.sv
`timescale 1ns/1ps
module tb_iic_init_seq;

  localparam int GAP = 20;
  localparam int RTO = 64;
  localparam int MS  = 1000;
  localparam int PWR = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  tbl_addr, entry_idx, slave_addr;
  logic [15:0] reg_addr;
  logic [7:0]  send_data;
  logic        send_rw, send_en, brust, init_busy, init_done;
  logic [23:0] tbl [0:255];
  logic [23:0] rom_q = '0;

  // dut1: single-entry table for the zero-length delay case
  logic [7:0]  tbl_addr1, entry_idx1, slave_addr1, send_data1;
  logic [15:0] reg_addr1;
  logic        send_rw1, send_en1, brust1, init_busy1, init_done1;

  always @(posedge clk) rom_q <= tbl[tbl_addr];

  // iic_master model
  logic m_busy = 1'b0, m_act = 1'b0, m_en_q = 1'b0, m_dead = 1'b0;
  int   m_cnt = 0;
  int   cyc = 0;
  logic [23:0] frames[$];
  int   rise_t[$];
  logic en1_q = 1'b0;
  int   n_rise1 = 0;

  iic_init_seq #(.CLK_FRE(1), .PWR_DELAY_MS(PWR), .TBL_AW(8), .TBL_LEN(3),
                 .SLAVE_ADDR(8'h78), .GAP_CYC(GAP), .REQ_TIMEOUT(RTO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_tbl_addr(tbl_addr),
    .i_tbl_data(rom_q), .o_iic_slave_addr(slave_addr), .o_iic_send_rw(send_rw),
    .o_iic_reg_addr(reg_addr), .o_iic_send_data(send_data), .o_iic_send_en(send_en),
    .o_iic_brust_vaild(brust), .i_iic_send_busy(m_busy), .o_init_busy(init_busy),
    .o_init_done(init_done), .o_entry_idx(entry_idx));

  iic_init_seq #(.CLK_FRE(1), .PWR_DELAY_MS(PWR), .TBL_AW(8), .TBL_LEN(1),
                 .SLAVE_ADDR(8'h78), .GAP_CYC(GAP), .REQ_TIMEOUT(RTO)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(1'b0), .o_tbl_addr(tbl_addr1),
    .i_tbl_data(24'hFFFF00), .o_iic_slave_addr(slave_addr1), .o_iic_send_rw(send_rw1),
    .o_iic_reg_addr(reg_addr1), .o_iic_send_data(send_data1), .o_iic_send_en(send_en1),
    .o_iic_brust_vaild(brust1), .i_iic_send_busy(1'b0), .o_init_busy(init_busy1),
    .o_init_done(init_done1), .o_entry_idx(entry_idx1));

  always @(posedge clk) cyc <= cyc + 1;

  // busy rises 3 cycles after a send_en rising edge and stays up 40 cycles
  always @(posedge clk) begin
    m_en_q <= send_en;
    en1_q  <= send_en1;
    if (send_en1 && !en1_q) n_rise1 <= n_rise1 + 1;
    if (send_en && !m_en_q) rise_t.push_back(cyc);
    if (m_act) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 1)  m_busy <= 1'b1;
      if (m_cnt == 41) begin m_busy <= 1'b0; m_act <= 1'b0; end
    end else if (send_en && !m_en_q && !m_dead) begin
      m_act <= 1'b1;
      m_cnt <= 0;
      frames.push_back({reg_addr, send_data});
    end
  end

  int n_chk = 0, n_err = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    n_chk++;
    assert (v >= lo && v <= hi) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected in [%0d,%0d]", tag, v, lo, hi);
    end
  endtask

  // Reference: frames expected in table order, plus a run-time window built from
  // the per-entry costs (fetch/load 2, frame 40, gap, delay ms*1000).
  task automatic model(input int len, output int lo, output int hi);
    exp_q.delete();
    lo = PWR * MS;
    for (int i = 0; i < len; i++) begin
      if (tbl[i][23:8] == 16'hFFFF) lo += 2 + int'(tbl[i][7:0]) * MS;
      else begin exp_q.push_back(tbl[i]); lo += 2 + 40 + GAP; end
    end
    hi = lo + 15 * len + 10;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!init_done && k < budget) begin @(negedge clk); k++; end
    chk("done_reached", init_done, 1'b1);
  endtask

  task automatic pulse_start(output int t0);
    @(negedge clk); start = 1'b1; t0 = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int t0);
    int lo, hi, n;
    model(3, lo, hi);
    wait_done(hi + 200);
    chk_rng({tag, "_run_cycles"}, cyc - t0, lo, hi);
    chk({tag, "_frame_cnt"}, frames.size(), exp_q.size());
    n = (frames.size() < exp_q.size()) ? frames.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_frame%0d", tag, i), frames[i], exp_q[i]);
    chk({tag, "_idx_last"}, entry_idx, 2);
  endtask

  task automatic rand_table();
    for (int i = 0; i < 3; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) tbl[i] = {16'hFFFF, 8'($urandom_range(0, 1))};
      else begin
        tbl[i] = 24'($urandom);
        if (tbl[i][23:8] == 16'hFFFF) tbl[i][23:8] = 16'h1234;
      end
    end
  endtask

  initial begin
    int t0, t1, k, bad, lows, r0;
    for (int i = 0; i < 256; i++) tbl[i] = 24'h0;
    tbl[0] = 24'h300882; tbl[1] = 24'h310303; tbl[2] = 24'h3017FF;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_tbl_addr", tbl_addr, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_send_data", send_data, 0);
    chk("rst_send_en", send_en, 0);
    chk("rst_init_busy", init_busy, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_entry_idx", entry_idx, 0);
    chk("const_slave_addr", slave_addr, 8'h78);
    chk("const_rw", send_rw, 0);
    chk("const_brust", brust, 0);
    chk("rst1_init_done", init_done1, 0);

    // T1 + T6: release reset, both instances auto-run
    @(negedge clk); rst_n = 1'b1; t0 = cyc;
    repeat (2) @(negedge clk);
    chk("t1_busy_after_auto", init_busy, 1'b1);
    k = 0;
    while (!init_done1 && k < 1200) begin @(negedge clk); k++; end
    chk("t6_done", init_done1, 1'b1);
    chk_rng("t6_run_cycles", cyc - t0, PWR * MS, PWR * MS + 25);
    chk("t6_idx", entry_idx1, 0);
    check_run("t1", t0);

    // T2: delay entry of 5 ms before the write; rerun from DONE
    tbl[0] = 24'hFFFF05; tbl[1] = 24'h300802; tbl[2] = 24'hFFFF00;
    frames.delete(); rise_t.delete();
    pulse_start(t0);
    chk("t2_done_drops", init_done, 1'b0);
    chk("t2_busy", init_busy, 1'b1);
    check_run("t2", t0);
    chk("t2_rise_cnt", rise_t.size(), 1);
    if (rise_t.size() > 0) chk_rng("t2_first_rise", rise_t[0] - t0, 6 * MS, 6 * MS + 30);

    // T5 + random tables: replay via start, one run gets a start during XFER
    for (int it = 0; it < 3; it++) begin
      rand_table();
      frames.delete(); rise_t.delete();
      pulse_start(t0);
      chk($sformatf("r%0d_done_drops", it), init_done, 1'b0);
      if (it == 1) begin
        k = 0;
        while (!m_busy && k < 3000) begin @(negedge clk); k++; end
        chk("t5_master_busy", m_busy, 1'b1);
        repeat (3) @(negedge clk);
        pulse_start(t1);
        chk("t5_xfer_start_ignored", init_busy, 1'b1);
      end
      check_run($sformatf("r%0d", it), t0);
    end

    // T4: reset during XFER of entry 1
    tbl[0] = 24'h300882; tbl[1] = 24'h310303; tbl[2] = 24'h3017FF;
    frames.delete(); rise_t.delete();
    pulse_start(t0);
    k = 0;
    while (!(frames.size() == 2 && m_busy) && k < 3000) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    chk("t4_in_entry1", entry_idx, 1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_send_en", send_en, 0);
    chk("t4_rst_busy", init_busy, 0);
    chk("t4_rst_idx", entry_idx, 0);
    chk("t4_rst_reg_addr", reg_addr, 0);
    chk("t4_rst_send_data", send_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; t0 = cyc;
    frames.delete(); rise_t.delete();
    check_run("t4", t0);
    if (rise_t.size() > 0) chk_rng("t4_first_rise", rise_t[0] - t0, PWR * MS, PWR * MS + 30);

    // T3: master never answers; request drops one cycle every RTO cycles
    m_dead = 1'b1;
    frames.delete(); rise_t.delete();
    pulse_start(t0);
    k = 0;
    while (rise_t.size() == 0 && k < 3000) begin @(negedge clk); k++; end
    chk("t3_first_rise", rise_t.size() > 0, 1'b1);
    r0 = (rise_t.size() > 0) ? rise_t[0] : cyc;
    bad = 0; lows = 0;
    for (int i = 0; i < 3 * (RTO + 1); i++) begin
      @(negedge clk);
      if (send_en !== (((cyc - r0) % (RTO + 1)) != RTO)) bad++;
      if (!send_en) lows++;
    end
    chk("t3_pattern_bad_cycles", bad, 0);
    chk("t3_low_cycles", lows, 3);
    chk("t3_no_done", init_done, 0);
    chk("t3_busy", init_busy, 1'b1);
    chk("t3_idx", entry_idx, 0);
    chk("t3_no_frames", frames.size(), 0);
    chk("t6_no_send_en", n_rise1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
